// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: pipeline bus widths, ALU/memory op bit indices and divider state encoding.
// Rev 1.0
`default_nettype none
package ex_stage_pkg;
  localparam int DS_TO_ES_W = 155;
  localparam int ES_TO_MS_W = 78;
  localparam int ES_RF_W    = 39;

  localparam int ALU_OP_W = 12;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam int MI_ST_B  = 0;
  localparam int MI_ST_H  = 1;
  localparam int MI_ST_W  = 2;
  localparam int MI_LD_BU = 3;
  localparam int MI_LD_W  = 7;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
endpackage
`default_nettype wire

// File: rtl/alu.sv
// alu: 12-op one-hot ALU shared by the execute stage.
// Rev 1.0
`default_nettype none
module alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         alu_src1,
  input  logic [31:0]         alu_src2,
  output logic [31:0]         alu_result
);
  logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res;

  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
  assign sltu_res = {31'd0, alu_src1 < alu_src2};
  assign sll_res  = alu_src1 << alu_src2[4:0];
  assign srl_res  = alu_src1 >> alu_src2[4:0];
  assign sra_res  = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

  assign alu_result = ({32{alu_op[ALU_ADD]}}  & add_res)
                    | ({32{alu_op[ALU_SUB]}}  & sub_res)
                    | ({32{alu_op[ALU_SLT]}}  & slt_res)
                    | ({32{alu_op[ALU_SLTU]}} & sltu_res)
                    | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[ALU_SLL]}}  & sll_res)
                    | ({32{alu_op[ALU_SRL]}}  & srl_res)
                    | ({32{alu_op[ALU_SRA]}}  & sra_res)
                    | ({32{alu_op[ALU_LUI]}}  & alu_src2);
endmodule
`default_nettype wire

// File: rtl/div_iter.sv
// div_iter: restoring radix-2 divider, one quotient bit per cycle, 32 iterations.
// Rev 1.0
`default_nettype none
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        ack,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] quo, rem, dsr;
  logic        neg_q, neg_r, dsr_zero;
  logic [31:0] abs_a, abs_b, diff;
  logic [32:0] shifted;
  logic        fits;

  assign abs_a   = (is_signed & dividend[31]) ? (32'd0 - dividend) : dividend;
  assign abs_b   = (is_signed & divisor[31])  ? (32'd0 - divisor)  : divisor;
  assign shifted = {rem, quo[31]};
  assign fits    = shifted >= {1'b0, dsr};
  // The trial difference is below the divisor whenever it is kept, so 32 bits suffice.
  assign diff    = shifted[31:0] - dsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= DIV_IDLE;
      count    <= 5'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dsr      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dsr_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state    <= DIV_BUSY;
          count    <= 5'd0;
          quo      <= abs_a;
          rem      <= 32'd0;
          dsr      <= abs_b;
          neg_q    <= is_signed & (dividend[31] ^ divisor[31]);
          neg_r    <= is_signed & dividend[31];
          dsr_zero <= (divisor == 32'd0);
        end
        DIV_BUSY: begin
          rem   <= fits ? diff : shifted[31:0];
          quo   <= {quo[30:0], fits};
          count <= count + 5'd1;
          if (count == 5'd31) state <= DIV_DONE;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = dsr_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo) : quo);
  assign remainder = neg_r ? (32'd0 - rem) : rem;
endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
// ex_stage: execute stage - ALU, multiply, iterative divide, data-SRAM request and forwarding bundle.
// Rev 1.0
`default_nettype none
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ds_to_es_valid,
  output logic                  es_allowin,
  input  logic [DS_TO_ES_W-1:0] ds_to_es_bus,
  input  logic [7:0]            mem_inst_bus,
  input  logic                  ms_allowin,
  output logic                  es_to_ms_valid,
  output logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  output logic [ES_RF_W-1:0]    es_rf_collect,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata
);
  logic                  es_valid;
  logic [DS_TO_ES_W-1:0] es_bus;
  logic [7:0]            es_mem_inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid    <= 1'b0;
      es_bus      <= '0;
      es_mem_inst <= 8'd0;
    end else begin
      if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) begin
        es_bus      <= ds_to_es_bus;
        es_mem_inst <= mem_inst_bus;
      end
    end
  end

  logic                mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu;
  logic [ALU_OP_W-1:0] alu_op;
  logic                res_from_mem, mem_en, rf_we;
  logic [31:0]         src1, src2, rkd_value, pc;
  logic [4:0]          rf_waddr;

  assign {mul_w, mulh_w, mulh_wu, div_w, mod_w, div_wu, mod_wu} = es_bus[154:148];
  assign alu_op       = es_bus[147:136];
  assign res_from_mem = es_bus[135];
  assign src1         = es_bus[134:103];
  assign src2         = es_bus[102:71];
  assign mem_en       = es_bus[70];
  assign rf_we        = es_bus[69];
  assign rf_waddr     = es_bus[68:64];
  assign rkd_value    = es_bus[63:32];
  assign pc           = es_bus[31:0];

  logic [31:0] alu_result;
  alu u_alu (
    .alu_op     (alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  // Sign-extending to 64 bits keeps the low 64 product bits exact for both signednesses.
  logic [63:0] mul_a, mul_b, mul_prod;
  assign mul_a    = {{32{mulh_w & src1[31]}}, src1};
  assign mul_b    = {{32{mulh_w & src2[31]}}, src2};
  assign mul_prod = mul_a * mul_b;

  logic        div_op, div_done, es_ready_go;
  logic [31:0] quotient, remainder;
  assign div_op = div_w | mod_w | div_wu | mod_wu;

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (es_valid & div_op),
    .ack       (es_to_ms_valid & ms_allowin),
    .is_signed (div_w | mod_w),
    .dividend  (src1),
    .divisor   (src2),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign es_ready_go    = ~div_op | div_done;
  assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;

  logic [31:0] es_result;
  always_comb begin
    es_result = alu_result;
    if (mul_w)                  es_result = mul_prod[31:0];
    else if (mulh_w | mulh_wu)  es_result = mul_prod[63:32];
    else if (div_w | div_wu)    es_result = quotient;
    else if (mod_w | mod_wu)    es_result = remainder;
  end

  logic st_w, st_h, st_b;
  assign st_w = es_mem_inst[MI_ST_W];
  assign st_h = es_mem_inst[MI_ST_H];
  assign st_b = es_mem_inst[MI_ST_B];

  assign data_sram_addr  = alu_result;
  assign data_sram_en    = es_valid & (res_from_mem | mem_en) & ms_allowin;
  assign data_sram_we    = ~(mem_en & es_valid & ms_allowin) ? 4'b0000 :
                           st_w ? 4'b1111 :
                           st_h ? (4'b0011 << data_sram_addr[1:0]) :
                           st_b ? (4'b0001 << data_sram_addr[1:0]) : 4'b0000;
  assign data_sram_wdata = st_b ? {4{rkd_value[7:0]}} :
                           st_h ? {2{rkd_value[15:0]}} : rkd_value;

  assign es_to_ms_bus  = {res_from_mem, rf_we, rf_waddr, es_result, pc,
                          es_mem_inst[MI_LD_W:MI_LD_BU], data_sram_addr[1:0]};
  assign es_rf_collect = {es_valid & (res_from_mem | div_op), es_valid & rf_we, rf_waddr, es_result};
endmodule
`default_nettype wire
